// File: rtl/seq_acc_pkg.sv
// seq_acc_pkg: shared widths, saturation constant and FSM states for the product accumulator
package seq_acc_pkg;
    localparam int PROD_W = 25;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sat_add_u.sv
// sat_add_u: unsigned saturating add of a zero-extended addend onto an accumulator
module sat_add_u #(
    parameter int ACC_W = 32,
    parameter int PROD_W = 25
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] add_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);
    logic [ACC_W:0] wide;
    assign wide = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, add_i};
    assign ovf_o = wide[ACC_W];
    assign sum_o = ovf_o ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
endmodule

// File: rtl/seq_prod_accumulator.sv
// seq_prod_accumulator: sums a programmed number of multiplier products into a saturating block sum
module seq_prod_accumulator #(
    parameter int PROD_W = seq_acc_pkg::PROD_W,
    parameter int ACC_W = seq_acc_pkg::ACC_W,
    parameter int CNT_W = seq_acc_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_Start,
    input  logic [CNT_W-1:0]  in_Count,
    input  logic [PROD_W-1:0] in_Prod,
    input  logic              in_Valid,
    output logic              in_Ready,
    output logic [ACC_W-1:0]  out_Sum,
    output logic              out_Valid,
    input  logic              out_Ready,
    output logic              out_Ovf,
    output logic              Busy
);
    import seq_acc_pkg::*;

    state_t state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic ovf_q, ovf_d, carry, start_ok;

    sat_add_u #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .acc_i(acc_q),
        .add_i(in_Prod),
        .sum_o(sum),
        .ovf_o(carry)
    );

    assign out_Sum = acc_q;
    assign out_Ovf = ovf_q;

    // next state: product transfer in ACCUM, block start from IDLE or chained onto the output handshake, release to IDLE
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        rem_d = rem_q;
        start_ok = in_Start && (state_q == IDLE || (state_q == DONE && out_Ready));
        if (state_q == ACCUM && in_Valid) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
            rem_d = rem_q - CNT_W'(1);
            state_d = rem_q == CNT_W'(1) ? DONE : ACCUM;
        end else if (start_ok) begin
            acc_d = '0;
            ovf_d = 1'b0;
            rem_d = in_Count;
            state_d = in_Count == '0 ? DONE : ACCUM;
        end else if (state_q == DONE && out_Ready) begin
            state_d = IDLE;
        end
    end

    // state, datapath and handshake outputs registered together; asynchronous clear
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            acc_q <= '0;
            ovf_q <= 1'b0;
            rem_q <= '0;
            in_Ready <= 1'b0;
            out_Valid <= 1'b0;
            Busy <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            rem_q <= rem_d;
            in_Ready <= state_d == ACCUM;
            out_Valid <= state_d == DONE;
            Busy <= state_d != IDLE;
        end
    end
endmodule

// File: tb/tb_seq_prod_accumulator.sv
// tb_seq_prod_accumulator: scoreboard bench with a block-level sum model and random stimulus
module tb_seq_prod_accumulator;
    localparam int PROD_W = 25;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;

    logic CLK = 0, RESET = 0, in_Start = 0, in_Valid = 0, out_Ready = 0;
    logic [CNT_W-1:0] in_Count = '0;
    logic [PROD_W-1:0] in_Prod = '0;
    logic in_Ready, out_Valid, out_Ovf, Busy;
    logic [ACC_W-1:0] out_Sum;
    int vectors = 0, miscompares = 0;
    logic [ACC_W:0] sb[$];
    logic [ACC_W:0] mon_e;
    logic [PROD_W-1:0] prods[$];

    always #5 CLK = ~CLK;

    seq_prod_accumulator dut (
        .CLK(CLK), .RESET(RESET), .in_Start(in_Start), .in_Count(in_Count),
        .in_Prod(in_Prod), .in_Valid(in_Valid), .in_Ready(in_Ready),
        .out_Sum(out_Sum), .out_Valid(out_Valid), .out_Ready(out_Ready),
        .out_Ovf(out_Ovf), .Busy(Busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // block result = true sum clipped to the accumulator range, overflow when the true sum does not fit
    function automatic logic [ACC_W:0] model();
        longint unsigned total = 0;
        foreach (prods[i]) total += longint'(prods[i]);
        return total > 64'hFFFF_FFFF ? {1'b1, {ACC_W{1'b1}}} : {1'b0, total[ACC_W-1:0]};
    endfunction

    always @(negedge CLK) begin
        if (RESET && out_Valid && out_Ready) begin
            if (sb.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("sb_sum", out_Sum, mon_e[ACC_W-1:0]);
                chk("sb_ovf", out_Ovf, mon_e[ACC_W]);
            end
        end
    end

    task automatic do_block(input int bp, input bit keep, input bit gaps);
        logic [ACC_W:0] e = model();
        int i = 0, t = 0;
        logic took, g;
        sb.push_back(e);
        in_Start = 1;
        in_Count = CNT_W'(prods.size());
        out_Ready = out_Valid;
        @(posedge CLK); #1;
        in_Start = 0;
        out_Ready = 0;
        if (prods.size() == 0) chk("zero_cnt_valid", out_Valid, 1);
        else chk("first_ready", in_Ready, 1);
        while (i < prods.size()) begin
            g = gaps && $urandom_range(0, 3) == 0;
            in_Valid = !g;
            in_Prod = g ? PROD_W'($urandom) : prods[i];
            in_Start = g;
            in_Count = CNT_W'($urandom);
            took = in_Valid && in_Ready;
            @(posedge CLK); #1;
            if (took) i++;
            t++;
            if (t > 4 * prods.size() + 16) begin
                chk("feed_timeout", 64'(t), 0);
                break;
            end
        end
        in_Valid = 0;
        in_Start = 0;
        chk("done_valid", out_Valid, 1);
        chk("done_sum", out_Sum, e[ACC_W-1:0]);
        chk("done_ovf", out_Ovf, e[ACC_W]);
        chk("done_ready_low", in_Ready, 0);
        repeat (bp) begin
            @(posedge CLK); #1;
            chk("hold_valid", out_Valid, 1);
            chk("hold_sum", out_Sum, e[ACC_W-1:0]);
            chk("hold_ready_low", in_Ready, 0);
        end
        if (!keep) begin
            out_Ready = 1;
            @(posedge CLK); #1;
            out_Ready = 0;
            chk("idle_busy", Busy, 0);
            chk("idle_valid", out_Valid, 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        bit keep;
        #12;
        chk("rst_in_ready", in_Ready, 0);
        chk("rst_out_valid", out_Valid, 0);
        chk("rst_out_sum", out_Sum, 0);
        chk("rst_out_ovf", out_Ovf, 0);
        chk("rst_busy", Busy, 0);
        @(posedge CLK); #1 RESET = 1;
        @(posedge CLK); #1;

        prods = {25'd1, 25'd2, 25'd3};
        do_block(0, 0, 0);
        prods.delete();
        repeat (128) prods.push_back(25'h1FEFE01);
        do_block(0, 0, 0);
        prods.push_back(25'h1FEFE01);
        do_block(0, 0, 0);
        prods.delete();
        do_block(0, 0, 0);
        prods = {25'd5, 25'd7};
        do_block(5, 0, 0);
        prods = {25'd100, 25'd200, 25'd300, 25'd400, 25'd500, 25'd600};
        do_block(1, 1, 1);
        prods = {25'h1FFFFFF, 25'd9, 25'd10};
        do_block(2, 1, 0);
        prods.delete();
        do_block(1, 1, 0);
        prods = {25'd42};
        do_block(0, 0, 0);

        in_Start = 1;
        in_Count = 10;
        @(posedge CLK); #1;
        in_Start = 0;
        in_Valid = 1;
        repeat (4) begin
            in_Prod = PROD_W'($urandom);
            @(posedge CLK); #1;
        end
        chk("pre_reset_busy", Busy, 1);
        #2 RESET = 0;
        #1;
        chk("mid_rst_in_ready", in_Ready, 0);
        chk("mid_rst_out_valid", out_Valid, 0);
        chk("mid_rst_out_sum", out_Sum, 0);
        chk("mid_rst_out_ovf", out_Ovf, 0);
        chk("mid_rst_busy", Busy, 0);
        in_Valid = 0;
        @(posedge CLK); #1 RESET = 1;
        @(posedge CLK); #1;
        prods = {25'd11, 25'd22, 25'd33};
        do_block(0, 0, 0);

        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(0, 5) == 0 ? $urandom_range(0, 2)
              : ($urandom_range(0, 7) == 0 ? $urandom_range(120, 255) : $urandom_range(1, 30));
            prods.delete();
            repeat (n) prods.push_back($urandom_range(0, 1) ? PROD_W'($urandom) : PROD_W'($urandom_range(0, 255)));
            keep = b != 29 && $urandom_range(0, 1) == 1;
            do_block($urandom_range(0, 3), keep, 1);
        end

        repeat (2) @(posedge CLK);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
